// File: rtl/apb_be_ram.sv
// Single-port byte-enable RAM with a registered read port.
// The read register updates every cycle from the current address.
module apb_be_ram #(
    parameter int DW    = 32,
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [DW/8-1:0] be,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW / 8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/apb_wait_mem.sv
// APB memory slave with programmable wait states, a read-only low
// region, optional privileged-write checking and PSLVERR responses.
module apb_wait_mem #(
    parameter int C_APB_ADDR_WIDTH = 12,
    parameter int C_APB_DATA_WIDTH = 32,
    parameter int MEM_WORDS        = 1024,
    parameter int WAIT_STATES      = 0,
    parameter int RO_WORDS         = 0,
    parameter int OPT_PRIV_WRITE   = 0
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic                          PSEL,
    input  logic                          PENABLE,
    output logic                          PREADY,
    input  logic [C_APB_ADDR_WIDTH-1:0]   PADDR,
    input  logic                          PWRITE,
    input  logic [C_APB_DATA_WIDTH-1:0]   PWDATA,
    input  logic [C_APB_DATA_WIDTH/8-1:0] PWSTRB,
    input  logic [2:0]                    PPROT,
    output logic [C_APB_DATA_WIDTH-1:0]   PRDATA,
    output logic                          PSLVERR
);

    localparam int AW     = C_APB_ADDR_WIDTH;
    localparam int DW     = C_APB_DATA_WIDTH;
    localparam int APBLSB = $clog2(DW) - 3;
    localparam int IW     = AW - APBLSB;
    localparam int RAW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int CW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    localparam logic [IW:0]   MEM_LIM = (IW + 1)'(MEM_WORDS);
    localparam logic [IW:0]   RO_LIM  = (IW + 1)'(RO_WORDS);
    localparam logic [CW-1:0] CNT_LD  = CW'(WAIT_STATES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           pready_q, pready_d;
    logic           pslverr_q, pslverr_d;
    logic           rsel_q, rsel_d;
    logic [DW-1:0]  prdata_q, prdata_d;

    logic [IW-1:0]  widx;
    logic [IW:0]    widx_x;
    logic           err_c;
    logic           fin;
    logic           fin_err;
    logic           ram_we;
    logic [DW-1:0]  ram_rdata;
    logic           unused_ok;

    assign widx   = PADDR[AW-1:APBLSB];
    assign widx_x = {1'b0, widx};

    // The read-only test is written as idx+1 <= limit so RO_WORDS=0
    // never becomes an always-false unsigned compare.
    assign err_c = (widx_x >= MEM_LIM)
                 | (PWRITE & ((widx_x + (IW + 1)'(1)) <= RO_LIM))
                 | (PWRITE & (OPT_PRIV_WRITE != 0) & ~PPROT[0]);

    assign unused_ok = ^{PPROT[2:1], PADDR};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rsel_d    = 1'b0;
        prdata_d  = prdata_q;
        ram_we    = 1'b0;
        fin       = 1'b0;
        fin_err   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    err_d   = err_c;
                    cnt_d   = CNT_LD;
                    fin_err = err_c;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RESP;
                        fin     = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (PENABLE) begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_RESP;
                        fin     = 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                ram_we   = PSEL & PENABLE & PWRITE & ~err_q;
                prdata_d = rsel_q ? ram_rdata : prdata_q;
            end
            default: state_d = S_IDLE;
        endcase
        // A successful read shows the RAM output directly during the
        // PREADY cycle and is captured into prdata_q when it ends.
        if (fin) begin
            pready_d  = 1'b1;
            pslverr_d = fin_err;
            rsel_d    = ~PWRITE & ~fin_err;
            if (!PWRITE && fin_err) prdata_d = '0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            rsel_q    <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            rsel_q    <= rsel_d;
            prdata_q  <= prdata_d;
        end
    end

    apb_be_ram #(
        .DW    (DW),
        .WORDS (MEM_WORDS),
        .AW    (RAW)
    ) u_ram (
        .clk   (PCLK),
        .we    (ram_we),
        .be    (PWSTRB),
        .addr  (widx[RAW-1:0]),
        .wdata (PWDATA),
        .rdata (ram_rdata)
    );

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = rsel_q ? ram_rdata : prdata_q;

endmodule

// File: tb/tb_apb_wait_mem.sv
// Directed bench: three slave configurations on one shared APB bus,
// each selected by its own PSEL.
module tb_apb_wait_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic [2:0]  pprot;
    logic        pready  [3];
    logic        pslverr [3];
    logic [31:0] prdata  [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    apb_wait_mem #(
        .MEM_WORDS(256), .WAIT_STATES(0), .RO_WORDS(4), .OPT_PRIV_WRITE(1)
    ) u_a (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
        .PREADY(pready[0]), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_wait_mem #(.WAIT_STATES(3)) u_b (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
        .PREADY(pready[1]), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    apb_wait_mem #(.WAIT_STATES(2)) u_c (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
        .PREADY(pready[2]), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PWSTRB(pwstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PSLVERR(pslverr[2])
    );

    typedef struct {
        int          d;
        logic [11:0] a;
        logic        w;
        logic [31:0] wd;
        logic [3:0]  st;
        logic [2:0]  pr;
        logic [31:0] erd;
        logic        chk_rd;
        logic        eer;
        int          eacc;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic [11:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, output logic [31:0] rd,
                        output logic er, output int acc);
        @(posedge clk); #1;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = wd;
        pwstrb  = st;
        pprot   = pr;
        @(negedge clk);
        chk($sformatf("setup_pready_d%0d", d), {31'b0, pready[d]}, 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        acc = 0;
        do begin
            @(negedge clk);
            acc++;
        end while (!pready[d] && acc < 20);
        rd = prdata[d];
        er = pslverr[d];
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel    = '0;
        penable = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("idle_pready_d%0d", i), {31'b0, pready[i]}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd, v;
        logic        er;
        int          acc;

        rst_n = 1'b0; psel = '0; penable = 1'b0; paddr = '0;
        pwrite = 1'b0; pwdata = '0; pwstrb = '0; pprot = '0;

        vt.push_back('{0, 12'h010, 1, 32'h12345678, 4'hF, 3'b001, 32'h0,        0, 0, 1});
        vt.push_back('{0, 12'h010, 0, 32'h0,        4'h0, 3'b001, 32'h12345678, 1, 0, 1});
        vt.push_back('{0, 12'h010, 1, 32'hAABBCCDD, 4'h5, 3'b001, 32'h0,        0, 0, 1});
        vt.push_back('{0, 12'h010, 0, 32'h0,        4'h0, 3'b001, 32'h12BB56DD, 1, 0, 1});
        vt.push_back('{0, 12'h400, 0, 32'h0,        4'h0, 3'b001, 32'h0,        1, 1, 1});
        vt.push_back('{0, 12'h010, 1, 32'hFFFFFFFF, 4'h0, 3'b001, 32'h0,        0, 0, 1});
        vt.push_back('{0, 12'h010, 0, 32'h0,        4'h0, 3'b001, 32'h12BB56DD, 1, 0, 1});
        vt.push_back('{0, 12'h020, 1, 32'h01020304, 4'hF, 3'b001, 32'h0,        0, 0, 1});
        vt.push_back('{0, 12'h020, 1, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        0, 1, 1});
        vt.push_back('{0, 12'h020, 0, 32'h0,        4'h0, 3'b001, 32'h01020304, 1, 0, 1});
        vt.push_back('{0, 12'h020, 1, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0,        0, 0, 1});
        vt.push_back('{0, 12'h020, 0, 32'h0,        4'h0, 3'b000, 32'hDEADBEEF, 1, 0, 1});
        vt.push_back('{0, 12'hFFC, 1, 32'h55555555, 4'hF, 3'b001, 32'h0,        0, 1, 1});
        vt.push_back('{0, 12'hFFC, 0, 32'h0,        4'h0, 3'b001, 32'h0,        1, 1, 1});
        vt.push_back('{1, 12'h010, 1, 32'h12345678, 4'hF, 3'b000, 32'h0,        0, 0, 4});
        vt.push_back('{1, 12'h010, 0, 32'h0,        4'h0, 3'b000, 32'h12345678, 1, 0, 4});
        vt.push_back('{1, 12'h3FC, 1, 32'hA5A5A5A5, 4'hF, 3'b000, 32'h0,        0, 0, 4});
        vt.push_back('{1, 12'h3FE, 0, 32'h0,        4'h0, 3'b000, 32'hA5A5A5A5, 1, 0, 4});
        vt.push_back('{2, 12'h010, 1, 32'h0000AAAA, 4'hF, 3'b000, 32'h0,        0, 0, 3});
        vt.push_back('{2, 12'h010, 0, 32'h0,        4'h0, 3'b000, 32'h0000AAAA, 1, 0, 3});

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_pready_d%0d", i), {31'b0, pready[i]}, 32'd0);
            chk($sformatf("rst_pslverr_d%0d", i), {31'b0, pslverr[i]}, 32'd0);
            chk($sformatf("rst_prdata_d%0d", i), prdata[i], 32'd0);
        end

        foreach (vt[i]) begin
            xfer(vt[i].d, vt[i].a, vt[i].w, vt[i].wd, vt[i].st, vt[i].pr,
                 rd, er, acc);
            chk($sformatf("v%0d_latency", i), acc, vt[i].eacc);
            chk($sformatf("v%0d_pslverr", i), {31'b0, er}, {31'b0, vt[i].eer});
            if (vt[i].chk_rd)
                chk($sformatf("v%0d_prdata", i), rd, vt[i].erd);
        end
        idle();

        // read-only word survives a rejected write
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 3'b001, v, er, acc);
        chk("ro_pre_err", {31'b0, er}, 32'd0);
        xfer(0, 12'h004, 1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, er, acc);
        chk("ro_wr_err", {31'b0, er}, 32'd1);
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 3'b001, rd, er, acc);
        chk("ro_unchanged", rd, v);
        idle();

        // reset while PREADY is high on a zero-wait write
        @(posedge clk); #1;
        psel = 3'b001; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1;
        pwdata = 32'hCAFEF00D; pwstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("rstresp_pready_hi", {31'b0, pready[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstresp_pready_async", {31'b0, pready[0]}, 32'd0);
        chk("rstresp_pslverr", {31'b0, pslverr[0]}, 32'd0);
        @(posedge clk); #1;
        psel = '0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 12'h010, 0, 32'h0, 4'h0, 3'b001, rd, er, acc);
        chk("rstresp_nocommit", rd, 32'h12BB56DD);
        chk("rstresp_latency", acc, 1);
        idle();

        // reset in the second access cycle of a two-wait write
        @(posedge clk); #1;
        psel = 3'b100; penable = 1'b0; paddr = 12'h010; pwrite = 1'b1;
        pwdata = 32'h5555FFFF; pwstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        chk("rstwait_acc1", {31'b0, pready[2]}, 32'd0);
        @(negedge clk);
        chk("rstwait_acc2", {31'b0, pready[2]}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait_pready", {31'b0, pready[2]}, 32'd0);
        chk("rstwait_prdata", prdata[2], 32'd0);
        @(posedge clk); #1;
        chk("rstwait_held", {31'b0, pready[2]}, 32'd0);
        psel = '0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(2, 12'h010, 0, 32'h0, 4'h0, 3'b000, rd, er, acc);
        chk("rstwait_nocommit", rd, 32'h0000AAAA);
        chk("rstwait_latency", acc, 3);
        chk("rstwait_err", {31'b0, er}, 32'd0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_wait_mem.md
Name: apb_wait_mem

Overview:
- Parametrised APB memory slave; successor to the team's single-cycle demo APB slave.
- Adds a configurable depth smaller than the address space, programmable wait states and a read-only low region.
- Adds optional privileged-write enforcement and real PSLVERR generation.
- Sits behind an APB bridge as a scratch/config RAM and serves as a bus-checker target for wait/error paths.

Parameters:
- C_APB_ADDR_WIDTH, 12: PADDR width (AW).
- C_APB_DATA_WIDTH, 32: PWDATA/PRDATA width (DW); power of two, at least 8.
- MEM_WORDS, 1024: implemented words; at most 2^(AW-APBLSB).
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion; range 0..15.
- RO_WORDS, 0: words 0..RO_WORDS-1 are read-only.
- OPT_PRIV_WRITE, 0: when 1, writes with PPROT[0]=0 are errors.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset; one clock, asynchronous active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PREADY  out  1  transfer completion.
- PADDR  in  AW  byte address.
- PWRITE  in  1  1 = write.
- PWDATA  in  DW  write data.
- PWSTRB  in  DW/8  byte lane enables.
- PPROT  in  3  protection; only bit 0 is used.
- PRDATA  out  DW  read data.
- PSLVERR  out  1  error response, valid only with PREADY.

Behaviour:
- Word index: widx = PADDR[AW-1:APBLSB], where APBLSB = $clog2(DW)-3. Low address bits are ignored.
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, state=IDLE, counter=0. Memory contents are not reset.
- Reset asserted mid-transfer: outputs clear immediately. A pending write is never committed.
- States:
  - IDLE: PSEL&!PENABLE (setup) -> latch err and load counter with WAIT_STATES -> WAIT if WAIT_STATES>0, else RESP.
  - WAIT: PSEL&PENABLE -> decrement counter; when counter reaches 1 -> RESP. If PSEL drops (protocol violation) -> IDLE, no side effects.
  - RESP: PREADY=1 for exactly one cycle -> IDLE.
- Latency: PREADY rises in access-phase cycle WAIT_STATES+1. With WAIT_STATES=0 this matches the zero-wait legacy timing.
- Back-to-back transfers: a new setup in the cycle after PREADY is accepted.
- PREADY is registered. PREADY is never high outside PSEL&PENABLE.
- err sources, evaluated in the setup cycle:
  - widx >= MEM_WORDS (any direction).
  - Write with widx < RO_WORDS.
  - Write with OPT_PRIV_WRITE=1 and PPROT[0]=0.
- PSLVERR=err only in the PREADY cycle; 0 otherwise.
- Write commit: occurs on the edge ending the PREADY cycle, only if PWRITE&!err. Only PWSTRB-enabled bytes change. PWSTRB=0 gives a legal no-op with OKAY response.
- Read: PRDATA is loaded on the edge that raises PREADY.
  - mem[widx] when !err; 0 when err.
  - PRDATA holds its value otherwise.
- Read-after-write: an immediately following read returns the new data; no bypass is needed.
- Counter width: max(1, $clog2(WAIT_STATES+1)). No wrap; the counter saturates at 0.
- PPROT[2:1] and the low address bits are unused; tie them to a lint sink.

Decomposition:
- No shared package; all constants (APBLSB, counter width, state encodings) are localparams.
- One sub-module, apb_be_ram: single-port, byte-enable, synchronous-read RAM of MEM_WORDS×DW.
  - Ports: clk, we, be, addr, wdata, rdata.
  - The FSM/error logic stays in apb_wait_mem.
- Formal: reuse the fapb_slave interface checker with F_OPT_MAXSTALL=WAIT_STATES+1. Use an anyconst-address shadow word for the data contract.

Test Plan:
- WAIT_STATES=0: write 0x12345678 to 0x010, strobe 4'hF, then read 0x010 -> PREADY in the first access cycle of each transfer; PRDATA=0x12345678; PSLVERR=0.
- WAIT_STATES=3: read 0x010 -> PREADY low for 3 access cycles, high on the 4th for one cycle; PRDATA valid then.
- Partial strobe: write 0xAABBCCDD with PWSTRB=4'b0101 over 0x12345678 -> read returns 0x12BB56DD.
- MEM_WORDS=256, read 0x400 -> PSLVERR=1, PRDATA=0. RO_WORDS=4, write 0x004 -> PSLVERR=1, and a subsequent read is unchanged.
- OPT_PRIV_WRITE=1: write 0xDEADBEEF with PPROT=3'b000 -> PSLVERR=1, no change. The same write with PPROT=3'b001 -> OKAY and committed.
- WAIT_STATES=2: assert PRESETn low during the second access cycle of a write -> PREADY drops asynchronously; memory is unchanged; the next transfer after reset completes normally.
